// File: rtl/pong_game_ctrl_if.sv
// Pong controller bus: the tick strobe and player controls in, game state out.
// The master modport drives the controls. The slave modport is the controller.
interface pong_game_ctrl_if;
  logic       tick;
  logic       start;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic [9:0] ballx;
  logic [9:0] bally;
  logic [9:0] p1;
  logic [9:0] p2;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [2:0] state;
  logic       game_over;

  modport master (
    output tick, start, p1_up, p1_down, p2_up, p2_down,
    input  ballx, bally, p1, p2, score1, score2, state, game_over
  );

  modport slave (
    input  tick, start, p1_up, p1_down, p2_up, p2_down,
    output ballx, bally, p1, p2, score1, score2, state, game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-state sequencer. It owns the ball position and direction, both
// paddles and both scores. It runs the serve delay, wall bounce, paddle hit,
// miss/score and game-over sequence. State advances only on cycles where tick=1.
// Optional feature: define PONG_CPU_P2_EN to let P2 track the ball by itself.
// In that build p2_up/p2_down are ignored.
module pong_game_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_X1   = 16,
  parameter int PADDLE_X2   = 616,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_SPEED  = 2,
  parameter int SERVE_TICKS = 30,
  parameter int WIN_SCORE   = 7
) (
  input  logic            clk,
  input  logic            reset,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    SCORE = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(SERVE_TICKS);

  localparam logic [9:0]        BALL_CX   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]        BALL_CY   = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]        PAD_START = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0]        PAD_MAX   = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0]        PAD_STEP  = 10'(PADDLE_STEP);
  localparam logic [3:0]        WIN       = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SERVE_TICKS - 1);

  // Ball arithmetic is done in 11-bit signed so a step past either edge
  // shows up as a real out-of-range value instead of wrapping.
  localparam logic signed [10:0] SPD      = 11'(BALL_SPEED);
  localparam logic signed [10:0] Y_MAX    = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0] X_MAX    = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0] X_HIT_L  = 11'(PADDLE_X1 + PADDLE_W);
  localparam logic signed [10:0] X_HIT_R  = 11'(PADDLE_X2 - BALL_SIZE);

  state_t           state_q;
  logic [9:0]       ballx_q, bally_q, p1_q, p2_q;
  logic [3:0]       score1_q, score2_q;
  logic             dx_pos_q, dy_pos_q;   // 1 = moving right / down
  logic             left_miss_q;          // last point was conceded by P1
  logic             game_over_q;
  logic [CNT_W-1:0] serve_cnt_q;

  logic [9:0]         p1_next, p2_next;
  logic               p2_up_eff, p2_dn_eff;
  logic signed [10:0] nx, ny;
  logic [10:0]        by_ext;
  logic               ov1, ov2;
  logic [9:0]         play_x, play_y;
  logic               play_dx, play_dy, miss_left, miss_right;

  // Saturating paddle move; pressing both directions holds the paddle.
  function automatic logic [9:0] paddle_step(input logic [9:0] p,
                                             input logic up,
                                             input logic down);
    paddle_step = p;
    if (up && !down)
      paddle_step = (p >= PAD_STEP) ? p - PAD_STEP : 10'd0;
    else if (down && !up)
      paddle_step = (p + PAD_STEP >= PAD_MAX) ? PAD_MAX : p + PAD_STEP;
  endfunction

`ifdef PONG_CPU_P2_EN
  logic [10:0] ball_mid, p2_mid;
  assign ball_mid  = {1'b0, bally_q} + 11'(BALL_SIZE / 2);
  assign p2_mid    = {1'b0, p2_q} + 11'(PADDLE_H / 2);
  assign p2_up_eff = ball_mid < p2_mid;
  assign p2_dn_eff = ball_mid > p2_mid;
`else
  assign p2_up_eff = bus.p2_up;
  assign p2_dn_eff = bus.p2_down;
`endif

  assign p1_next = paddle_step(p1_q, bus.p1_up, bus.p1_down);
  assign p2_next = paddle_step(p2_q, p2_up_eff, p2_dn_eff);

  // Candidate ball position, direction and miss flags for one PLAY tick.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch. Otherwise synthesis infers a latch.
    nx         = $signed({1'b0, ballx_q}) + (dx_pos_q ? SPD : -SPD);
    ny         = $signed({1'b0, bally_q}) + (dy_pos_q ? SPD : -SPD);
    by_ext     = {1'b0, bally_q};
    ov1        = (by_ext + 11'(BALL_SIZE) > {1'b0, p1_q}) &&
                 (by_ext < {1'b0, p1_q} + 11'(PADDLE_H));
    ov2        = (by_ext + 11'(BALL_SIZE) > {1'b0, p2_q}) &&
                 (by_ext < {1'b0, p2_q} + 11'(PADDLE_H));
    play_y     = ny[9:0];
    play_dy    = dy_pos_q;
    play_x     = nx[9:0];
    play_dx    = dx_pos_q;
    miss_left  = 1'b0;
    miss_right = 1'b0;

    if (ny <= 11'sd0) begin
      play_y  = 10'd0;
      play_dy = 1'b1;
    end else if (ny >= Y_MAX) begin
      play_y  = Y_MAX[9:0];
      play_dy = 1'b0;
    end

    // A paddle hit takes priority over a miss on the same side.
    if (!dx_pos_q && nx <= X_HIT_L && ov1) begin
      play_x  = X_HIT_L[9:0];
      play_dx = 1'b1;
    end else if (dx_pos_q && nx >= X_HIT_R && ov2) begin
      play_x  = X_HIT_R[9:0];
      play_dx = 1'b0;
    end else if (nx <= 11'sd0) begin
      play_x    = 10'd0;
      miss_left = 1'b1;
    end else if (nx >= X_MAX) begin
      play_x     = X_MAX[9:0];
      miss_right = 1'b1;
    end
  end

  // Game FSM: all game state and registered outputs change only on tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ballx_q     <= BALL_CX;
      bally_q     <= BALL_CY;
      p1_q        <= PAD_START;
      p2_q        <= PAD_START;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      dx_pos_q    <= 1'b1;
      dy_pos_q    <= 1'b1;
      left_miss_q <= 1'b0;
      game_over_q <= 1'b0;
      serve_cnt_q <= '0;
    end else if (bus.tick) begin
      // NOTE: state registers use non-blocking assignment, so every branch reads the values from before this edge.
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= SERVE;
            serve_cnt_q <= '0;
          end
        end

        SERVE: begin
          p1_q    <= p1_next;
          p2_q    <= p2_next;
          ballx_q <= BALL_CX;
          bally_q <= BALL_CY;
          if (serve_cnt_q == CNT_LAST) begin
            state_q <= PLAY;
          end else begin
            serve_cnt_q <= serve_cnt_q + 1'b1;
          end
        end

        PLAY: begin
          p1_q     <= p1_next;
          p2_q     <= p2_next;
          ballx_q  <= play_x;
          bally_q  <= play_y;
          dx_pos_q <= play_dx;
          dy_pos_q <= play_dy;
          if (miss_left) begin
            if (score2_q < WIN) score2_q <= score2_q + 1'b1;
            left_miss_q <= 1'b1;
            state_q     <= SCORE;
          end else if (miss_right) begin
            if (score1_q < WIN) score1_q <= score1_q + 1'b1;
            left_miss_q <= 1'b0;
            state_q     <= SCORE;
          end
        end

        SCORE: begin
          ballx_q  <= BALL_CX;
          bally_q  <= BALL_CY;
          // Serve toward the player who just conceded.
          dx_pos_q <= !left_miss_q;
          if (score1_q == WIN || score2_q == WIN) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
          end else begin
            state_q     <= SERVE;
            serve_cnt_q <= '0;
          end
        end

        OVER: begin
          if (bus.start) begin
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            ballx_q     <= BALL_CX;
            bally_q     <= BALL_CY;
            game_over_q <= 1'b0;
            serve_cnt_q <= '0;
            state_q     <= SERVE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ballx     = ballx_q;
  assign bus.bally     = bally_q;
  assign bus.p1        = p1_q;
  assign bus.p2        = p2_q;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.state     = state_q;
  assign bus.game_over = game_over_q;

endmodule
